// File: rtl/usb_regs_pkg.sv
// ---------------------------------------------------------------------------
// usb_regs_pkg
// Shared constants for the USB-to-AHB-Lite status/error register bank.
//   - default widths of the status, error, occupancy, EHTS and counter fields
//   - bit positions of the named error sources and status flags
// ---------------------------------------------------------------------------
package usb_regs_pkg;

    localparam int NUM_STATUS = 16;
    localparam int NUM_ERR    = 16;
    localparam int OCC_W      = 7;
    localparam int EHTS_W     = 8;
    localparam int CNT_W      = 8;

    // Error source bit positions
    localparam int ERR_RX = 0;
    localparam int ERR_TX = 8;

    // Status flag bit positions
    localparam int ST_RX_DATA_READY = 0;
    localparam int ST_RX_ACTIVE     = 8;
    localparam int ST_TX_ACTIVE     = 9;

endpackage

// File: rtl/usb_status_regs_if.sv
// ---------------------------------------------------------------------------
// usb_status_regs_if
// Bundles every non-clock/reset signal of the status register bank.
//   master : the RX/TX packet logic and AHB-Lite slave side.
//            It drives the flags, error sources, strobes, occupancy and EHTS data.
//   slave  : the register bank. It drives statusData, errorData, errEnable,
//            errIrq, errCount, boData, boHighWater and ehtsData.
// ---------------------------------------------------------------------------
interface usb_status_regs_if
    import usb_regs_pkg::*;
#(
    parameter int NUM_STATUS = usb_regs_pkg::NUM_STATUS,
    parameter int NUM_ERR    = usb_regs_pkg::NUM_ERR,
    parameter int OCC_W      = usb_regs_pkg::OCC_W,
    parameter int EHTS_W     = usb_regs_pkg::EHTS_W,
    parameter int CNT_W      = usb_regs_pkg::CNT_W
);

    logic [NUM_STATUS-1:0] statusIn;
    logic [NUM_ERR-1:0]    errIn;
    logic [NUM_ERR-1:0]    errClear;
    logic                  errEnableWrite;
    logic [NUM_ERR-1:0]    enableData;
    logic                  cntClear;
    logic [OCC_W-1:0]      bufferOccupancy;
    logic                  hwmClear;
    logic [EHTS_W-1:0]     nextEHTSData;
    logic                  ehtsLoad;

    logic [NUM_STATUS-1:0] statusData;
    logic [NUM_ERR-1:0]    errorData;
    logic [NUM_ERR-1:0]    errEnable;
    logic                  errIrq;
    logic [CNT_W-1:0]      errCount;
    logic [OCC_W-1:0]      boData;
    logic [OCC_W-1:0]      boHighWater;
    logic [EHTS_W-1:0]     ehtsData;

    modport master (
        output statusIn, errIn, errClear, errEnableWrite, enableData,
               cntClear, bufferOccupancy, hwmClear, nextEHTSData, ehtsLoad,
        input  statusData, errorData, errEnable, errIrq, errCount,
               boData, boHighWater, ehtsData
    );

    modport slave (
        input  statusIn, errIn, errClear, errEnableWrite, enableData,
               cntClear, bufferOccupancy, hwmClear, nextEHTSData, ehtsLoad,
        output statusData, errorData, errEnable, errIrq, errCount,
               boData, boHighWater, ehtsData
    );

endinterface

// File: rtl/usb_status_regs_rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
// Per-bit rising-edge detector that holds the previous-cycle copy of its input.
//   clk   : system clock
//   nRst  : asynchronous active-low reset. It clears the history to 0.
//   in    : sampled vector
//   rise  : in & ~history. It is combinational from in.
// Because the history resets to 0, a bit that is already high when reset is
// released reports a rise at the first clock edge.
// ---------------------------------------------------------------------------
module rise_detect #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] errPrev;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            errPrev <= '0;
        end else begin
            errPrev <= in;
        end
    end

    assign rise = in & ~errPrev;

endmodule

// File: rtl/usb_status_regs.sv
// ---------------------------------------------------------------------------
// usb_status_regs
// Status/error register bank for the USB-to-AHB-Lite slave path.
//   clk  : system clock. All state updates on the rising edge.
//   nRst : asynchronous active-low reset. It clears every register.
//   bus  : usb_status_regs_if.slave
//          Inputs : status flags, error sources, W1C clears, enable write,
//                   counter/high-water clears, occupancy, EHTS load.
//          Outputs: registered status, sticky errors, enables, interrupt,
//                   saturating event counter, occupancy, high-water mark, EHTS.
// Every output comes straight from a flop, so there is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module usb_status_regs
    import usb_regs_pkg::*;
#(
    parameter int NUM_STATUS = usb_regs_pkg::NUM_STATUS,
    parameter int NUM_ERR    = usb_regs_pkg::NUM_ERR,
    parameter int OCC_W      = usb_regs_pkg::OCC_W,
    parameter int EHTS_W     = usb_regs_pkg::EHTS_W,
    parameter int CNT_W      = usb_regs_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              nRst,
    usb_status_regs_if.slave  bus
);

    localparam int PC_W  = $clog2(NUM_ERR + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    logic [NUM_STATUS-1:0] statusQ;
    logic [NUM_ERR-1:0]    errorQ;
    logic [NUM_ERR-1:0]    enableQ;
    logic                  irqQ;
    logic [CNT_W-1:0]      countQ;
    logic [OCC_W-1:0]      occQ;
    logic [OCC_W-1:0]      hwmQ;
    logic [EHTS_W-1:0]     ehtsQ;

    logic [NUM_ERR-1:0]    rise;
    logic [PC_W-1:0]       riseCount;
    logic [CNT_W-1:0]      countBase;

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_ERR-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_ERR; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // The add is done one bit wider than either operand, so an overflow is
    // visible and clamps to all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a,
                                                input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    rise_detect #(.WIDTH(NUM_ERR)) uRiseDetect (
        .clk  (clk),
        .nRst (nRst),
        .in   (bus.errIn),
        .rise (rise)
    );

    // cntClear restarts from zero but still adds this cycle's events.
    assign riseCount = popcount(rise);
    assign countBase = bus.cntClear ? '0 : countQ;

    // Sticky errors: set has priority over the W1C clear, so no event is lost.
    // The interrupt looks at the registered error and enable bits, which adds
    // one cycle of delay after errorData.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            errorQ  <= '0;
            enableQ <= '0;
            irqQ    <= 1'b0;
            countQ  <= '0;
        end else begin
            errorQ <= rise | (errorQ & ~bus.errClear);
            if (bus.errEnableWrite) begin
                enableQ <= bus.enableData;
            end
            irqQ   <= |(errorQ & enableQ);
            countQ <= satAdd(countBase, riseCount);
        end
    end

    // Status, occupancy, high-water mark and EHTS registers.
    // hwmClear reloads the tracker with the current occupancy.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            statusQ <= '0;
            occQ    <= '0;
            hwmQ    <= '0;
            ehtsQ   <= '0;
        end else begin
            statusQ <= bus.statusIn;
            occQ    <= bus.bufferOccupancy;
            if (bus.hwmClear || (bus.bufferOccupancy > hwmQ)) begin
                hwmQ <= bus.bufferOccupancy;
            end
            if (bus.ehtsLoad) begin
                ehtsQ <= bus.nextEHTSData;
            end
        end
    end

    assign bus.statusData  = statusQ;
    assign bus.errorData   = errorQ;
    assign bus.errEnable   = enableQ;
    assign bus.errIrq      = irqQ;
    assign bus.errCount    = countQ;
    assign bus.boData      = occQ;
    assign bus.boHighWater = hwmQ;
    assign bus.ehtsData    = ehtsQ;

endmodule
